// File: rtl/convolucion_ventana_multicanal_if.sv
// Window-job / result bundle for the multichannel convolution engine.
// master drives jobs and collects results; slave is the engine side.
interface convolucion_ventana_multicanal_if #(
    parameter int BITS_PIXEL            = 8,
    parameter int BITS_ELEMENTO_MASCARA = 10,
    parameter int TAMANO_MAX            = 5,
    parameter int CANALES               = 3,
    parameter int BITS_DENOMINADOR      = 10
);
    localparam int N = TAMANO_MAX * TAMANO_MAX;

    logic                                ventana_pixeles_lista;
    logic                                listo_para_ventana;
    logic [2:0]                          tamano_mascara;
    logic [1:0]                          modo;
    logic [BITS_DENOMINADOR-1:0]         denominador;
    logic [N*BITS_ELEMENTO_MASCARA-1:0]  mascara;
    logic [CANALES*N*BITS_PIXEL-1:0]     ventana;
    logic [CANALES*BITS_PIXEL-1:0]       pixel_resultado;
    logic                                pixel_calculado;
    logic                                error_parametro;

    modport master (
        output ventana_pixeles_lista, tamano_mascara, modo,
        output denominador, mascara, ventana,
        input  listo_para_ventana, pixel_resultado,
        input  pixel_calculado, error_parametro
    );

    modport slave (
        input  ventana_pixeles_lista, tamano_mascara, modo,
        input  denominador, mascara, ventana,
        output listo_para_ventana, pixel_resultado,
        output pixel_calculado, error_parametro
    );
endinterface

// File: rtl/convolucion_ventana_multicanal.sv
// Multichannel window convolution: one shared signed mask, one element
// per cycle for all channels, then divide/shift and clamp to pixel range.
module convolucion_ventana_multicanal #(
    parameter int BITS_PIXEL            = 8,
    parameter int BITS_ELEMENTO_MASCARA = 10,
    parameter int TAMANO_MAX            = 5,
    parameter int CANALES               = 3,
    parameter int BITS_DENOMINADOR      = 10
) (
    input logic clk,
    input logic reset,
    convolucion_ventana_multicanal_if.slave bus
);
    localparam int N  = TAMANO_MAX * TAMANO_MAX;
    localparam int BP = BITS_PIXEL;
    localparam int BM = BITS_ELEMENTO_MASCARA;
    localparam int BD = BITS_DENOMINADOR;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int AW = BP + BM + $clog2(N);
    localparam int PW = BM + BP + 1;
    localparam int DW = (AW > BD) ? AW : BD;
    localparam logic [DW-1:0] MAXP = DW'((64'd1 << BP) - 64'd1);

    typedef enum logic [1:0] {ESPERA, ACUMULA, DIVIDE, ENTREGA} estado_t;

    estado_t                 estado_q, estado_d;
    logic [N*BM-1:0]         mascara_q, mascara_d;
    logic [CANALES*N*BP-1:0] ventana_q, ventana_d;
    logic [1:0]              modo_q, modo_d;
    logic [BD-1:0]           den_q, den_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [IW-1:0]           ultimo_q, ultimo_d;
    logic                    invalido_q, invalido_d;
    logic                    listo_q, listo_d;
    logic                    calculado_q, calculado_d;
    logic                    error_q, error_d;
    logic [CANALES*BP-1:0]   resultado_q, resultado_d;
    logic signed [AW-1:0]    acc_q [CANALES];
    logic signed [AW-1:0]    acc_d [CANALES];

    logic                    acepta;
    logic                    valido;
    logic [5:0]              lado_cuadrado;
    logic signed [PW-1:0]    coef;
    logic signed [PW-1:0]    pix [CANALES];
    logic signed [PW-1:0]    prod [CANALES];
    logic [AW-1:0]           magnitud [CANALES];
    logic signed [AW-1:0]    desplazado [CANALES];
    logic [DW-1:0]           cociente [CANALES];
    logic [DW-1:0]           valor [CANALES];
    logic [DW-1:0]           divisor;
    logic [CANALES*BP-1:0]   salida;

    assign acepta = bus.ventana_pixeles_lista && listo_q;

    // Job validity and element count from the incoming request.
    always_comb begin
        lado_cuadrado = {3'b0, bus.tamano_mascara} * {3'b0, bus.tamano_mascara};
        valido = bus.tamano_mascara[0]
              && (int'(bus.tamano_mascara) <= TAMANO_MAX)
              && ((bus.modo == 2'b10) || (bus.denominador != '0));
    end

    // Mask element times zero-extended pixel for the current index.
    always_comb begin
        coef = PW'($signed(mascara_q[int'(idx_q)*BM +: BM]));
        for (int c = 0; c < CANALES; c++) begin
            pix[c]  = $signed(PW'(ventana_q[(c*N + int'(idx_q))*BP +: BP]));
            prod[c] = coef * pix[c];
        end
    end

    // Final scaling per channel; negative results clamp to zero.
    always_comb begin
        divisor = (den_q == '0) ? DW'(1) : DW'(den_q);
        salida  = '0;
        for (int c = 0; c < CANALES; c++) begin
            magnitud[c]   = acc_q[c][AW-1] ? $unsigned(-acc_q[c])
                                           : $unsigned(acc_q[c]);
            desplazado[c] = acc_q[c] >>> den_q[4:0];
            cociente[c]   = DW'(magnitud[c]) / divisor;
            unique case (modo_q)
                2'b10:   valor[c] = desplazado[c][AW-1] ? '0
                                    : DW'($unsigned(desplazado[c]));
                2'b01:   valor[c] = cociente[c];
                default: valor[c] = acc_q[c][AW-1] ? '0 : cociente[c];
            endcase
            salida[c*BP +: BP] = (valor[c] > MAXP) ? '1 : valor[c][BP-1:0];
        end
    end

    // Sequencer next-state: accept, accumulate, scale, deliver.
    always_comb begin
        estado_d    = estado_q;
        mascara_d   = mascara_q;
        ventana_d   = ventana_q;
        modo_d      = modo_q;
        den_d       = den_q;
        idx_d       = idx_q;
        ultimo_d    = ultimo_q;
        invalido_d  = invalido_q;
        resultado_d = resultado_q;
        listo_d     = 1'b0;
        calculado_d = 1'b0;
        error_d     = 1'b0;
        for (int c = 0; c < CANALES; c++) begin
            acc_d[c] = acc_q[c];
        end
        unique case (estado_q)
            ESPERA: begin
                listo_d = 1'b1;
                if (acepta) begin
                    listo_d    = 1'b0;
                    mascara_d  = bus.mascara;
                    ventana_d  = bus.ventana;
                    modo_d     = bus.modo;
                    den_d      = bus.denominador;
                    idx_d      = '0;
                    ultimo_d   = IW'(lado_cuadrado - 6'd1);
                    invalido_d = !valido;
                    for (int c = 0; c < CANALES; c++) begin
                        acc_d[c] = '0;
                    end
                    estado_d = valido ? ACUMULA : DIVIDE;
                end
            end
            ACUMULA: begin
                for (int c = 0; c < CANALES; c++) begin
                    acc_d[c] = acc_q[c] + AW'(prod[c]);
                end
                idx_d = idx_q + IW'(1);
                if (idx_q == ultimo_q) begin
                    estado_d = DIVIDE;
                end
            end
            DIVIDE: begin
                resultado_d = invalido_q ? '0 : salida;
                calculado_d = 1'b1;
                error_d     = invalido_q;
                estado_d    = ENTREGA;
            end
            ENTREGA: begin
                listo_d  = 1'b1;
                estado_d = ESPERA;
            end
            default: estado_d = ESPERA;
        endcase
    end

    // State and registered outputs; reset aborts any job in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q    <= ESPERA;
            mascara_q   <= '0;
            ventana_q   <= '0;
            modo_q      <= '0;
            den_q       <= '0;
            idx_q       <= '0;
            ultimo_q    <= '0;
            invalido_q  <= 1'b0;
            listo_q     <= 1'b0;
            calculado_q <= 1'b0;
            error_q     <= 1'b0;
            resultado_q <= '0;
            for (int c = 0; c < CANALES; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            estado_q    <= estado_d;
            mascara_q   <= mascara_d;
            ventana_q   <= ventana_d;
            modo_q      <= modo_d;
            den_q       <= den_d;
            idx_q       <= idx_d;
            ultimo_q    <= ultimo_d;
            invalido_q  <= invalido_d;
            listo_q     <= listo_d;
            calculado_q <= calculado_d;
            error_q     <= error_d;
            resultado_q <= resultado_d;
            for (int c = 0; c < CANALES; c++) begin
                acc_q[c] <= acc_d[c];
            end
        end
    end

    assign bus.listo_para_ventana = listo_q;
    assign bus.pixel_resultado    = resultado_q;
    assign bus.pixel_calculado    = calculado_q;
    assign bus.error_parametro    = error_q;

endmodule

// File: doc/convolucion_ventana_multicanal.md
CONVOLUCION_VENTANA_MULTICANAL -- requirements
Module: convolucion_ventana_multicanal

Interface
REQ-001 Parameter BITS_PIXEL, default 8; unsigned pixel width.
REQ-002 Parameter BITS_ELEMENTO_MASCARA, default 10; signed mask element width.
REQ-003 Parameter TAMANO_MAX, default 5; largest odd mask side; N = TAMANO_MAX*TAMANO_MAX.
REQ-004 Parameter CANALES, default 3; channels processed in parallel with one shared mask.
REQ-005 Parameter BITS_DENOMINADOR, default 10; unsigned denominator width.
REQ-006 clk  in  1  single clock; all state changes on rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 ventana_pixeles_lista  in  1  window valid strobe.
REQ-009 listo_para_ventana  out  1  ready; window accepted on a rising edge where valid and ready are both 1.
REQ-010 tamano_mascara  in  3  mask side S.
REQ-011 modo  in  2  00 divide, 01 absolute-divide, 10 arithmetic shift, 11 same as 00.
REQ-012 denominador  in  BITS_DENOMINADOR  divisor (modes 00/01) or shift count from bits [4:0] (mode 10).
REQ-013 mascara  in  N*BITS_ELEMENTO_MASCARA  element k at [k*BITS_ELEMENTO_MASCARA +: BITS_ELEMENTO_MASCARA]; first S*S elements used, row-major.
REQ-014 ventana  in  CANALES*N*BITS_PIXEL  channel c element k at [(c*N+k)*BITS_PIXEL +: BITS_PIXEL]; same indexing as mascara.
REQ-015 pixel_resultado  out  CANALES*BITS_PIXEL  channel c at [c*BITS_PIXEL +: BITS_PIXEL].
REQ-016 pixel_calculado  out  1  one-cycle result-valid pulse.
REQ-017 error_parametro  out  1  pulses with pixel_calculado when the job was invalid.

Function
REQ-018 On acceptance, latch mascara, ventana, tamano_mascara, modo and denominador; input changes afterwards shall not affect the job.
REQ-019 FSM states: ESPERA (ready=1), ACUMULA, DIVIDE, ENTREGA; ESPERA->ACUMULA on acceptance; ACUMULA->DIVIDE after S*S elements; DIVIDE->ENTREGA after 1 cycle; ENTREGA->ESPERA after 1 cycle.
REQ-020 ACUMULA: one element index per cycle, starting at 0, for all channels; acc_c += signed(mascara[k]) * zero-extended ventana[c][k]; acc cleared at acceptance.
REQ-021 Accumulator width BITS_PIXEL+BITS_ELEMENTO_MASCARA+ceil(log2(N)), signed, no overflow possible.
REQ-022 Mode 00: acc/denominador, truncated toward zero; mode 01: |acc|/denominador; mode 10: acc arithmetically shifted right by denominador[4:0] (floor).
REQ-023 Each channel result clamped to [0, 2^BITS_PIXEL-1].
REQ-024 pixel_resultado and pixel_calculado registered on the (S*S+1)th rising edge after the acceptance edge; pixel_calculado high exactly one cycle; pixel_resultado holds until next result.
REQ-025 listo_para_ventana low from acceptance edge until the edge ending ENTREGA; throughput one window per S*S+3 cycles.
REQ-026 Invalid job when S is even, 0, or >TAMANO_MAX, or when denominador==0 in modes 00/01/11: ACUMULA is skipped (DIVIDE entered directly), pixel_resultado = 0, error_parametro pulses with pixel_calculado.
REQ-027 Valid job shall drive error_parametro 0.

Reset
REQ-028 While reset is low: state ESPERA, accumulators 0, pixel_resultado 0, pixel_calculado 0, error_parametro 0, listo_para_ventana 0.
REQ-029 listo_para_ventana rises on the first rising edge with reset high; reset mid-job aborts it with no pixel_calculado pulse.

Verification
REQ-030 S=3, mode 00, den 1, mask 0,-1,0,-1,5,-1,0,-1,0, channel 0 pixels 93,148,250,102,136,242,104,134,230 -> channel 0 result 54; pulse 10 edges after acceptance.
REQ-031 Same pixels, mask all 1, den 8: mode 00 -> 179; mode 10 with den 3 -> 179; mask all -1: mode 00 -> 0, mode 01 -> 179, mode 10 den 3 -> 0.
REQ-032 S=5, mask all 1, all pixels 255, den 1 -> 255 every channel; pulse 26 edges after acceptance; channels with pixels 0/1/10 -> 0/25/250.
REQ-033 den 0 mode 00, or S=4 -> result 0, error_parametro=1 with pixel_calculado, pulse 1 edge after acceptance; ready returns on the following edge.
REQ-034 Change mascara/ventana mid-ACUMULA -> result unchanged; reset low mid-ACUMULA -> no pulse, outputs 0, ready 0 until first edge after release.
REQ-035 Hold valid high continuously -> back-to-back jobs accepted exactly every S*S+3 cycles, one pulse each.
